alarm_tone_sequencer: RTL and testbench

Sequences the alarm audio datapath: it decides when the two DDS tone channels sound, and at what frequency, once the time-keeping block raises its alarm. It sits between the clock/alarm logic and the DDS phase accumulators plus left/right gating in front of the audio converter. It produces a stepped left/right beep pattern whose pitch escalates each pattern cycle, supports dismiss and a bounded snooze, and replaces the free-running 1 s left/right toggle.

---
 rtl/alarm_tone_sequencer_pkg.sv | 11 +
 rtl/alarm_tone_sequencer_if.sv | 14 +
 rtl/alarm_tone_sequencer_beat_timer.sv | 18 +
 rtl/alarm_tone_sequencer.sv | 131 +++++++++++++
 tb/tb_alarm_tone_sequencer.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alarm_tone_sequencer_pkg.sv
// alarm_pkg: shared states, tone table and beat-pattern constants for the alarm tone sequencer.
package alarm_pkg;
    typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_e;
    localparam int unsigned DDS_SCALE = 91626;
    localparam int unsigned PATTERN_BEATS = 8;
    localparam int unsigned TONE_BEATS = 4;
    localparam logic [31:0] FREQ [4] = '{32'd1000, 32'd1500, 32'd2000, 32'd2500};
    function automatic logic [31:0] dds_incr_of(input logic [1:0] lvl);
        return FREQ[lvl] * DDS_SCALE;
    endfunction
endpackage

// File: rtl/alarm_tone_sequencer_if.sv
// alarm_tone_sequencer_if: alarm/dismiss/snooze controls and tone-gating outputs of the sequencer.
interface alarm_tone_sequencer_if;
    logic alarm;
    logic dismiss;
    logic snooze;
    logic [31:0] dds_incr;
    logic on_l;
    logic on_r;
    logic ringing;
    logic snoozing;
    logic [1:0] level;
    modport master(output alarm, dismiss, snooze, input dds_incr, on_l, on_r, ringing, snoozing, level);
    modport slave(input alarm, dismiss, snooze, output dds_incr, on_l, on_r, ringing, snoozing, level);
endinterface

// File: rtl/alarm_tone_sequencer_beat_timer.sv
// beat_timer: tick counter emitting a one-cycle beat pulse every TICKS_PER_BEAT cycles; clr_i restarts at tick 0.
module beat_timer #(
    parameter int unsigned TICKS_PER_BEAT = 12_500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    output logic beat_o
);
    localparam int unsigned TW = $clog2(TICKS_PER_BEAT + 1);
    logic [TW-1:0] tick_q, tick_d;
    assign beat_o = ~clr_i & (tick_q == TW'(TICKS_PER_BEAT - 1));
    assign tick_d = (clr_i | beat_o) ? '0 : tick_q + TW'(1);
    always_ff @(posedge clk) begin
        if (rst) tick_q <= '0;
        else tick_q <= tick_d;
    end
endmodule

// File: rtl/alarm_tone_sequencer.sv
// alarm_tone_sequencer: stepped L/R beep pattern with pitch escalation, dismiss and bounded snooze.
// Snooze support is built only when ALARM_SNOOZE_EN is defined.
module alarm_tone_sequencer
    import alarm_pkg::*;
#(
    parameter int unsigned TICKS_PER_BEAT = 12_500_000,
    parameter int unsigned SNOOZE_BEATS = 1200,
    parameter int unsigned MAX_SNOOZE = 3
) (
    input logic clk,
    input logic rst,
    alarm_tone_sequencer_if.slave bus
);
    state_e state_q, state_d;
    logic [2:0] beat_q, beat_d;
    logic [1:0] level_q, level_d;
    logic alarm_d_q, on_l_q, on_r_q, ring_q, clr, beat, rise, ring_d, tone_d;
    logic [31:0] dds_q;
    assign rise = bus.alarm & ~alarm_d_q;
`ifdef ALARM_SNOOZE_EN
    localparam int unsigned SW = $clog2(SNOOZE_BEATS + 1);
    localparam int unsigned CW = $clog2(MAX_SNOOZE + 1);
    logic [SW-1:0] sbeat_q, sbeat_d;
    logic [CW-1:0] scnt_q, scnt_d;
    logic snz_q, snooze_ok;
    assign snooze_ok = bus.snooze & (scnt_q < CW'(MAX_SNOOZE));
    assign bus.snoozing = snz_q;
`else
    logic unused_cfg;
    assign unused_cfg = bus.snooze ^ (SNOOZE_BEATS == 0) ^ (MAX_SNOOZE == 0);
    assign bus.snoozing = 1'b0;
`endif
    beat_timer #(.TICKS_PER_BEAT(TICKS_PER_BEAT)) u_timer (.clk(clk), .rst(rst), .clr_i(clr), .beat_o(beat));
    always_comb begin
        state_d = state_q;
        beat_d = beat_q;
        level_d = level_q;
        clr = 1'b0;
`ifdef ALARM_SNOOZE_EN
        sbeat_d = sbeat_q;
        scnt_d = scnt_q;
`endif
        case (state_q)
            IDLE: begin
                clr = 1'b1;
                if (rise) begin
                    state_d = RING;
                    beat_d = '0;
                    level_d = '0;
`ifdef ALARM_SNOOZE_EN
                    scnt_d = '0;
`endif
                end
            end
            RING: begin
                if (bus.dismiss) begin
                    state_d = IDLE;
                    beat_d = '0;
                    level_d = '0;
                end
`ifdef ALARM_SNOOZE_EN
                else if (snooze_ok) begin
                    state_d = SNOOZE;
                    scnt_d = scnt_q + CW'(1);
                    sbeat_d = '0;
                    clr = 1'b1;
                end
`endif
                else if (beat) begin
                    beat_d = beat_q + 3'd1;
                    if (beat_q == 3'(PATTERN_BEATS - 1) && level_q != 2'd3) level_d = level_q + 2'd1;
                end
            end
`ifdef ALARM_SNOOZE_EN
            SNOOZE: begin
                if (bus.dismiss) begin
                    state_d = IDLE;
                    beat_d = '0;
                    level_d = '0;
                end else if (beat) begin
                    if (sbeat_q == SW'(SNOOZE_BEATS - 1)) begin
                        state_d = RING;
                        beat_d = '0;
                        level_d = '0;
                    end else sbeat_d = sbeat_q + SW'(1);
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end
    // outputs are decoded from next-state so gating changes on the same edge as the state
    assign ring_d = state_d == RING;
    assign tone_d = beat_d < 3'(TONE_BEATS);
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q <= '0;
            level_q <= '0;
            alarm_d_q <= 1'b1;
            on_l_q <= 1'b0;
            on_r_q <= 1'b0;
            ring_q <= 1'b0;
            dds_q <= dds_incr_of(2'd0);
`ifdef ALARM_SNOOZE_EN
            sbeat_q <= '0;
            scnt_q <= '0;
            snz_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            beat_q <= beat_d;
            level_q <= level_d;
            alarm_d_q <= bus.alarm;
            on_l_q <= ring_d & tone_d & beat_d[0];
            on_r_q <= ring_d & tone_d & ~beat_d[0];
            ring_q <= ring_d;
            dds_q <= dds_incr_of(level_d);
`ifdef ALARM_SNOOZE_EN
            sbeat_q <= sbeat_d;
            scnt_q <= scnt_d;
            snz_q <= state_d == SNOOZE;
`endif
        end
    end
    assign bus.on_l = on_l_q;
    assign bus.on_r = on_r_q;
    assign bus.ringing = ring_q;
    assign bus.level = level_q;
    assign bus.dds_incr = dds_q;
endmodule

// File: tb/tb_alarm_tone_sequencer.sv
// tb_alarm_tone_sequencer: directed and random stimulus checked against a time-based reference model.
module tb_alarm_tone_sequencer;
    localparam int T = 4;
    localparam int SB = 3;
    localparam int MS = 2;
`ifdef ALARM_SNOOZE_EN
    localparam bit SN_EN = 1'b1;
`else
    localparam bit SN_EN = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_checks = 0;
    int n_errors = 0;
    int freqs [4] = '{1000, 1500, 2000, 2500};
    // model: state (0 idle, 1 ring, 2 snooze), cycles since entry, snoozes used, level frozen at snooze
    int m_st = 0;
    int m_t = 0;
    int m_cnt = 0;
    int m_slvl = 0;
    bit m_prev = 1'b1;

    alarm_tone_sequencer_if bus();

    alarm_tone_sequencer #(.TICKS_PER_BEAT(T), .SNOOZE_BEATS(SB), .MAX_SNOOZE(MS)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic int ring_level(input int t);
        return (t / (8 * T) > 3) ? 3 : t / (8 * T);
    endfunction

    function automatic logic [37:0] exp_vec();
        int b;
        int lv;
        logic ring;
        lv = (m_st == 1) ? ring_level(m_t) : (m_st == 2) ? m_slvl : 0;
        b = (m_t / T) % 8;
        ring = m_st == 1;
        return {ring, logic'(m_st == 2), ring && b < 4 && b % 2 == 1, ring && b < 4 && b % 2 == 0,
                2'(lv), 32'(freqs[lv] * 91626)};
    endfunction

    function automatic logic [37:0] obs_vec();
        return {bus.ringing, bus.snoozing, bus.on_l, bus.on_r, bus.level, bus.dds_incr};
    endfunction

    task automatic model_update(input logic r, input logic a, input logic d, input logic s);
        bit rise;
        if (r) begin
            m_st = 0;
            m_t = 0;
            m_cnt = 0;
            m_prev = 1'b1;
            return;
        end
        rise = a && !m_prev;
        m_prev = a;
        case (m_st)
            0: if (rise) begin m_st = 1; m_t = 0; m_cnt = 0; end
            1: begin
                if (d) m_st = 0;
                else if (SN_EN && s && m_cnt < MS) begin
                    m_slvl = ring_level(m_t);
                    m_st = 2;
                    m_t = 0;
                    m_cnt++;
                end else m_t++;
            end
            default: begin
                if (d) m_st = 0;
                else begin
                    m_t++;
                    if (m_t == SB * T) begin m_st = 1; m_t = 0; end
                end
            end
        endcase
    endtask

    task automatic step(input logic r, input logic a, input logic d, input logic s);
        rst = r;
        bus.alarm = a;
        bus.dismiss = d;
        bus.snooze = s;
        @(posedge clk);
        model_update(r, a, d, s);
        #1;
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        n_checks++;
        if (obs_vec() !== exp_vec()) begin
            n_errors++;
            $display("FAIL reset_state got=%h want=%h", obs_vec(), exp_vec());
        end
        n_checks++;
        if (bus.dds_incr !== 32'd91626000) begin
            n_errors++;
            $display("FAIL reset_dds got=%0d want=91626000", bus.dds_incr);
        end
        step(0, 0, 0, 0);
    endtask

    task automatic test_basic();
        step(0, 1, 0, 0);
        n_checks++;
        if (obs_vec() !== exp_vec() || bus.on_r !== 1'b1) begin
            n_errors++;
            $display("FAIL ring_start got=%h want=%h", obs_vec(), exp_vec());
        end
        for (int i = 0; i < 40; i++) begin
            step(0, 1, 0, 0);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_errors++;
                $display("FAIL basic_ring cyc=%0d got=%h want=%h", i + 1, obs_vec(), exp_vec());
            end
            if (i == 31) begin
                n_checks++;
                if (bus.level !== 2'd1 || bus.dds_incr !== 32'd137439000) begin
                    n_errors++;
                    $display("FAIL level1_dds got=%0d/%0d want=1/137439000", bus.level, bus.dds_incr);
                end
            end
        end
    endtask

    task automatic test_escalation();
        for (int i = 0; i < 100; i++) begin
            step(0, 1, 0, 0);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_errors++;
                $display("FAIL escalation cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec());
            end
        end
        n_checks++;
        if (bus.level !== 2'd3 || bus.dds_incr !== 32'd229065000) begin
            n_errors++;
            $display("FAIL level_saturate got=%0d/%0d want=3/229065000", bus.level, bus.dds_incr);
        end
    endtask

    task automatic test_reset_midring();
        step(1, 1, 0, 0);
        n_checks++;
        if (obs_vec() !== exp_vec() || bus.ringing !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_midring got=%h want=%h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_snooze();
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step(0, 1, 0, 1);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_errors++;
                $display("FAIL snooze_entry k=%0d got=%h want=%h", k, obs_vec(), exp_vec());
            end
            for (int i = 0; i < 14; i++) begin
                step(0, 1, 0, 0);
                n_checks++;
                if (obs_vec() !== exp_vec()) begin
                    n_errors++;
                    $display("FAIL snooze_run k=%0d cyc=%0d got=%h want=%h", k, i, obs_vec(), exp_vec());
                end
            end
        end
        step(0, 1, 0, 1);
        n_checks++;
        if (bus.ringing !== 1'b1 || bus.snoozing !== 1'b0) begin
            n_errors++;
            $display("FAIL snooze_limit got=%b%b want=10", bus.ringing, bus.snoozing);
        end
    endtask

    task automatic test_dismiss_snooze();
        step(0, 1, 1, 1);
        n_checks++;
        if (obs_vec() !== exp_vec() || {bus.ringing, bus.snoozing, bus.on_l, bus.on_r} !== 4'b0000) begin
            n_errors++;
            $display("FAIL dismiss_snooze got=%h want=%h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_alarm_held();
        step(1, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 0, 0);
            n_checks++;
            if (obs_vec() !== exp_vec() || bus.ringing !== 1'b0) begin
                n_errors++;
                $display("FAIL alarm_held cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec());
            end
        end
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        n_checks++;
        if (obs_vec() !== exp_vec() || bus.ringing !== 1'b1) begin
            n_errors++;
            $display("FAIL alarm_rearm got=%h want=%h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_dismiss_idle();
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        step(0, 1, 1, 0);
        n_checks++;
        if (obs_vec() !== exp_vec() || bus.ringing !== 1'b1) begin
            n_errors++;
            $display("FAIL dismiss_idle got=%h want=%h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        logic a = 1'b0;
        logic d;
        logic s;
        step(1, 0, 0, 0);
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(39) == 0) a = ~a;
            d = $urandom_range(89) == 0;
            s = $urandom_range(14) == 0;
            step(0, a, d, s);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_errors++;
                $display("FAIL random cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        bus.alarm = 1'b0;
        bus.dismiss = 1'b0;
        bus.snooze = 1'b0;
        test_reset();
        test_basic();
        test_escalation();
        test_reset_midring();
        test_snooze();
        test_dismiss_snooze();
        test_alarm_held();
        test_dismiss_idle();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
